// File: rtl/stream_compass_conv3x3_if.sv
// Pixel stream bundle for stream_compass_conv3x3.
//   in_valid / in_ready / in_pixel : raster-order input pixel handshake
//   out_valid / out_pixel / out_dir / out_last : filtered output stream (no backpressure)
// master = pixel source / result sink side, slave = filter side.
interface stream_compass_conv3x3_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic [OUT_W-1:0]  out_pixel;
  logic [2:0]        out_dir;
  logic              out_last;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, out_valid, out_pixel, out_dir, out_last
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, out_valid, out_pixel, out_dir, out_last
  );
endinterface

// File: rtl/stream_compass_conv3x3.sv
// Streaming 3x3 edge-magnitude filter with programmable coefficients.
// Mode 0 applies the kernel as written; mode 1 applies all 8 45-degree ring
// rotations of it and reports the largest clamped magnitude and its direction.
// Exactly ROWS*COLS outputs per frame, border pixels forced to zero.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mode            0 single kernel, 1 compass max-of-8 (latched on first pixel)
//   coef_we/addr/wdata  coefficient write port, honoured only while idle
//   busy            high while a frame is being received or flushed
//   s               pixel stream (slave side of stream_compass_conv3x3_if)
module stream_compass_conv3x3 #(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  localparam int ACC_W = DATA_W + COEF_W + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     busy,
  stream_compass_conv3x3_if.slave  s
);

  localparam int NPIX   = ROWS * COLS;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int CNT_W  = $clog2(COLS + 1);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int LB_LEN = 2 * COLS + 2;
  // Clockwise ring of the 3x3 window (raster positions), centre 4 excluded.
  localparam int RING [8] = '{0, 1, 2, 5, 8, 7, 6, 3};
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_nx;

  logic [PIX_W-1:0]        in_cnt;
  logic [CNT_W-1:0]        fl_cnt;
  logic [CNT_W-1:0]        out_c;
  logic [ROW_W-1:0]        out_r;
  logic                    mode_r;
  logic signed [COEF_W-1:0] coef [9];
  logic [DATA_W-1:0]       lb [LB_LEN];

  logic accept, issue, last_in, flush_done, is_border, is_last;

  logic [DATA_W-1:0]       w_p0 [9];
  logic                    vld_p0, border_p0, last_p0, mode_p0;
  logic signed [ACC_W-1:0] sum_c [8];
  logic signed [ACC_W-1:0] sum_p1 [8];
  logic                    vld_p1, border_p1, last_p1, mode_p1;
  logic [OUT_W-1:0]        mag_c [8];
  logic [OUT_W-1:0]        best;
  logic [2:0]              best_dir;
  logic                    vld_p2, last_p2;
  logic [OUT_W-1:0]        pix_p2;
  logic [2:0]              dir_p2;

  function automatic logic signed [COEF_W-1:0] default_coef(input int i);
    case (i)
      0, 2:    return COEF_W'(1);
      1:       return COEF_W'(2);
      6, 8:    return COEF_W'(-1);
      7:       return COEF_W'(-2);
      default: return '0;
    endcase
  endfunction

  // Pixel is zero-extended so a full-scale value never reads as negative.
  function automatic logic signed [ACC_W-1:0] mul(input logic [DATA_W-1:0] px,
                                                  input logic signed [COEF_W-1:0] c);
    logic signed [ACC_W-1:0] a, b;
    a = $signed(ACC_W'(px));
    b = ACC_W'(c);
    return a * b;
  endfunction

  function automatic logic [OUT_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] a;
    a = v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
    return (a > MAG_MAX) ? MAG_MAX[OUT_W-1:0] : a[OUT_W-1:0];
  endfunction

  assign s.in_ready  = (state != FLUSH);
  assign busy        = (state != IDLE);
  assign accept      = s.in_valid && s.in_ready;
  assign last_in     = accept && (in_cnt == PIX_W'(NPIX - 1));
  assign flush_done  = (state == FLUSH) && (fl_cnt == CNT_W'(COLS));
  // Output k needs input k+COLS+1 as its bottom-right tap; the tail of the
  // frame (all border pixels) is issued by the flush cycles instead.
  assign issue       = (accept && (in_cnt >= PIX_W'(COLS + 1))) || (state == FLUSH);
  assign is_border   = (out_r == '0) || (out_r == ROW_W'(ROWS - 1)) ||
                       (out_c == '0) || (out_c == CNT_W'(COLS - 1));
  assign is_last     = (out_r == ROW_W'(ROWS - 1)) && (out_c == CNT_W'(COLS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)     state_nx = RUN;
      RUN:     if (last_in)    state_nx = FLUSH;
      FLUSH:   if (flush_done) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      fl_cnt    <= '0;
      out_r     <= '0;
      out_c     <= '0;
      mode_r    <= 1'b0;
      for (int i = 0; i < 9; i++) coef[i] <= default_coef(i);
      vld_p0    <= 1'b0;
      border_p0 <= 1'b0;
      last_p0   <= 1'b0;
      mode_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      last_p1   <= 1'b0;
      mode_p1   <= 1'b0;
      vld_p2    <= 1'b0;
      last_p2   <= 1'b0;
      pix_p2    <= '0;
      dir_p2    <= '0;
    end else begin
      state <= state_nx;
      if (accept) in_cnt <= last_in ? '0 : in_cnt + 1'b1;
      fl_cnt <= (state == FLUSH && !flush_done) ? fl_cnt + 1'b1 : '0;
      if (issue) begin
        if (out_c == CNT_W'(COLS - 1)) begin
          out_c <= '0;
          out_r <= is_last ? '0 : out_r + 1'b1;
        end else begin
          out_c <= out_c + 1'b1;
        end
      end
      if (state == IDLE && accept) mode_r <= mode;
      if (state == IDLE && coef_we && coef_addr < 4'd9) coef[coef_addr] <= coef_wdata;
      // p0: window captured
      vld_p0    <= issue;
      border_p0 <= is_border;
      last_p0   <= issue && is_last;
      mode_p0   <= mode_r;
      // p1: eight directional sums
      vld_p1    <= vld_p0;
      border_p1 <= border_p0;
      last_p1   <= last_p0;
      mode_p1   <= mode_p0;
      // p2: magnitude, max and clamp
      vld_p2    <= vld_p1;
      last_p2   <= vld_p1 && last_p1;
      if (vld_p1) begin
        pix_p2 <= border_p1 ? '0 : best;
        dir_p2 <= border_p1 ? '0 : best_dir;
      end
    end
  end

  // Two image lines plus two pixels: lb[m] holds the pixel accepted m+1 cycles ago.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0] <= s.in_pixel;
      for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
    end
    if (issue) begin
      w_p0[0] <= lb[2*COLS+1];
      w_p0[1] <= lb[2*COLS];
      w_p0[2] <= lb[2*COLS-1];
      w_p0[3] <= lb[COLS+1];
      w_p0[4] <= lb[COLS];
      w_p0[5] <= lb[COLS-1];
      w_p0[6] <= lb[1];
      w_p0[7] <= lb[0];
      w_p0[8] <= s.in_pixel;
    end
    for (int d = 0; d < 8; d++) sum_p1[d] <= sum_c[d];
  end

  // Direction d places coefficient K[RING[p-d]] at ring position RING[p].
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      sum_c[d] = mul(w_p0[4], coef[4]);
      for (int p = 0; p < 8; p++)
        sum_c[d] = sum_c[d] + mul(w_p0[RING[p]], coef[RING[(p + 8 - d) % 8]]);
    end
  end

  // Strict greater-than keeps the lowest direction on ties.
  always_comb begin
    for (int d = 0; d < 8; d++) mag_c[d] = mag(sum_p1[d]);
    best     = mag_c[0];
    best_dir = '0;
    if (mode_p1) begin
      for (int d = 1; d < 8; d++) begin
        if (mag_c[d] > best) begin
          best     = mag_c[d];
          best_dir = 3'(d);
        end
      end
    end
  end

  assign s.out_valid = vld_p2;
  assign s.out_pixel = pix_p2;
  assign s.out_dir   = dir_p2;
  assign s.out_last  = last_p2;

endmodule

// File: tb/tb_stream_compass_conv3x3.sv
module tb_stream_compass_conv3x3;
  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int NPIX = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic             coef_we = 1'b0;
  logic [3:0]       coef_addr = '0;
  logic signed [7:0] coef_wdata = '0;
  logic             busy;

  stream_compass_conv3x3_if #(.DATA_W(8), .OUT_W(8)) bus ();

  stream_compass_conv3x3 #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(8), .COEF_W(8), .OUT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .busy(busy),
    .s(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frame;
    int idx;
    int pix;
    int dir;
  } exp_t;

  exp_t tbl[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ocnt = 0;
  int opix [512];
  int odir [512];
  int olast[512];
  int ocyc [512];
  int img  [NPIX];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && ocnt < 512) begin
      opix[ocnt]  = int'(bus.out_pixel);
      odir[ocnt]  = int'(bus.out_dir);
      olast[ocnt] = int'(bus.out_last);
      ocyc[ocnt]  = cyc;
      ocnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] p);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < NPIX; k++) send_px(img[k][7:0]);
    idle_in();
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 8'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic wait_outputs(input int target, input string tag);
    int t;
    t = 0;
    while (ocnt < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check({tag, "_count"}, ocnt, target);
  endtask

  task automatic check_frame(input int fid, input int base, input string tag);
    for (int k = 0; k < NPIX; k++) begin
      int ep, ed;
      ep = 0;
      ed = 0;
      foreach (tbl[i]) begin
        if (tbl[i].frame == fid && tbl[i].idx == k) begin
          ep = tbl[i].pix;
          ed = tbl[i].dir;
        end
      end
      check($sformatf("%s_pix%0d", tag, k), opix[base+k], ep);
      check($sformatf("%s_dir%0d", tag, k), odir[base+k], ed);
      check($sformatf("%s_last%0d", tag, k), olast[base+k], (k == NPIX - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nlow, saved;

    // Frame 2: bright lower half; rows 1 and 2 see a -800 step, clamped to 255.
    for (int c = 1; c <= 3; c++) begin
      tbl.push_back('{2, 5 + c, 255, 0});
      tbl.push_back('{2, 10 + c, 255, 0});
    end
    // Frame 3: impulse of 10 at (2,2), compass mode.
    tbl.push_back('{3,  6, 20, 3});
    tbl.push_back('{3,  7, 20, 0});
    tbl.push_back('{3,  8, 20, 1});
    tbl.push_back('{3, 11, 20, 2});
    tbl.push_back('{3, 12,  0, 0});
    tbl.push_back('{3, 13, 20, 2});
    tbl.push_back('{3, 16, 20, 1});
    tbl.push_back('{3, 17, 20, 0});
    tbl.push_back('{3, 18, 20, 3});
    // Frame 5: identity kernel on a constant 100 image.
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        tbl.push_back('{5, r * COLS + c, 100, 0});

    bus.in_valid = 1'b0;
    bus.in_pixel = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_pixel", bus.out_pixel, 0);
    check("rst_out_dir", bus.out_dir, 0);
    @(negedge clk);
    rst = 1'b0;

    // Constant image, default kernel: everything cancels
    mode = 1'b0;
    base = ocnt;
    for (int k = 0; k < NPIX; k++) img[k] = 100;
    send_frame();
    check("t1_busy_after_send", busy, 1);
    wait_outputs(base + NPIX, "t1");
    check("t1_busy_idle", busy, 0);
    check_frame(1, base, "t1");

    // Horizontal edge
    base = ocnt;
    for (int k = 0; k < NPIX; k++) img[k] = (k < 2 * COLS) ? 0 : 200;
    send_frame();
    wait_outputs(base + NPIX, "t2");
    check_frame(2, base, "t2");

    // Impulse in compass mode
    mode = 1'b1;
    base = ocnt;
    for (int k = 0; k < NPIX; k++) img[k] = (k == 12) ? 10 : 0;
    send_frame();
    mode = 1'b0;
    wait_outputs(base + NPIX, "t3");
    check_frame(3, base, "t3");

    // Flush window with in_valid held high, then back-to-back next frame
    base = ocnt;
    for (int k = 0; k < NPIX; k++) send_px(8'd100);
    nlow = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      nlow++;
    end
    check("t4_ready_low_cycles", nlow, COLS + 1);
    check("t4_busy_after_flush", busy, 0);
    @(posedge clk);
    for (int k = 1; k < NPIX; k++) send_px(8'd100);
    idle_in();
    wait_outputs(base + 2 * NPIX, "t4");
    check("t4_flush_span", ocyc[base+24] - ocyc[base+18], 6);
    check("t4_flush_b2b", ocyc[base+24] - ocyc[base+19], 5);
    check_frame(4, base, "t4a");
    check_frame(4, base + NPIX, "t4b");

    // Coefficient write during RUN must be dropped
    base = ocnt;
    for (int k = 0; k < 10; k++) send_px(8'd100);
    write_coef(4, 1);
    for (int k = 11; k < NPIX; k++) send_px(8'd100);
    idle_in();
    wait_outputs(base + NPIX, "t5run");
    check_frame(4, base, "t5run");

    // Identity kernel written while idle
    for (int a = 0; a < 9; a++) write_coef(a, (a == 4) ? 1 : 0);
    write_coef(12, 55);
    base = ocnt;
    for (int k = 0; k < NPIX; k++) img[k] = 100;
    send_frame();
    wait_outputs(base + NPIX, "t5");
    check_frame(5, base, "t5");

    // Mid-frame reset
    for (int k = 0; k < 7; k++) send_px(8'd100);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", bus.in_ready, 1);
    saved = ocnt;
    repeat (4) @(posedge clk);
    check("t6_dropped", ocnt, saved);
    @(negedge clk);
    rst = 1'b0;
    base = ocnt;
    for (int k = 0; k < NPIX; k++) img[k] = 100;
    send_frame();
    wait_outputs(base + NPIX, "t6");
    check_frame(6, base, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
